spi_flash_responder: RTL and testbench

//  SPI mode-0 slave in the fabric that answers the MSS SPI_0 master as a serial NOR flash.

---
 rtl/spi_flash_responder.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_spi_flash_responder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_responder.sv
// spi_flash_responder
//   SPI mode-0 slave that answers an SPI master as a serial NOR flash, backed
//   by a 1-cycle-latency byte RAM port. SCK/SS_N/MOSI are oversampled on CLK
//   (CLK must be at least 8x the SCK frequency).
//
//   Opcodes: 0x03 READ, 0x05 RDSR, 0x9F JEDEC-ID.
//   Optional feature macro SPI_FLASH_RESP_PROGRAM_EN adds 0x06 WREN,
//   0x04 WRDI and 0x02 PAGE PROGRAM (requires MEM_AW >= 9).
//
// Ports
//   CLK        in   fabric clock
//   RESET      in   synchronous, active-high reset
//   SCK        in   SPI clock, idle low
//   SS_N       in   chip select, active low
//   MOSI       in   serial data from master
//   MISO       out  serial data to master
//   MISO_OE    out  MISO output enable (synchronized SS_N low)
//   MEM_ADDR   out  RAM byte address
//   MEM_RD     out  RAM read strobe, MEM_RDATA valid 1 CLK later
//   MEM_RDATA  in   RAM read data
//   MEM_WE     out  1-CLK RAM write strobe
//   MEM_WDATA  out  RAM write data
//   BUSY       out  high while synchronized SS_N is low
//   CMD_ERR    out  1-CLK pulse on an unsupported opcode
//
// state  | meaning
// -------+---------------------------------------------------------
// IDLE   | SS_N high, nothing in progress
// CMD    | shifting in the opcode byte
// ADDR   | shifting in the 3 address bytes (READ or PROGRAM)
// READ   | streaming RAM bytes out, prefetching one byte ahead
// STAT   | returning the status register every byte
// JEDEC  | returning the 3 ID bytes, then zeros
// PROG   | each complete data byte becomes one RAM write
// DONE   | WREN/WRDI accepted, MISO held low until SS_N high
// IGNORE | unsupported or refused command, MISO held low
module spi_flash_responder #(
  parameter int          MEM_AW   = 13,
  parameter logic [23:0] JEDEC_ID = 24'h20BA18
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              SCK,
  input  logic              SS_N,
  input  logic              MOSI,
  output logic              MISO,
  output logic              MISO_OE,
  output logic [MEM_AW-1:0] MEM_ADDR,
  output logic              MEM_RD,
  input  logic [7:0]        MEM_RDATA,
  output logic              MEM_WE,
  output logic [7:0]        MEM_WDATA,
  output logic              BUSY,
  output logic              CMD_ERR
);

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_ADDR, S_READ, S_STAT, S_JEDEC, S_PROG, S_DONE, S_IGNORE
  } state_t;

  state_t state, state_nxt;

  logic [1:0] sck_sync, ss_sync, mosi_sync;
  logic       sck_prev;
  logic       sck_s, ss_n_s, mosi_s;
  logic       sck_rise, sck_fall;

  logic [2:0]        bit_cnt;
  logic [1:0]        byte_cnt;
  logic [6:0]        rx;
  logic [7:0]        rx_next;
  logic              byte_done;
  logic [MEM_AW-2:0] addr_sr;
  logic [MEM_AW-1:0] addr_full;
  logic [7:0]        tx;
  logic [7:0]        pf;
  logic              rd_q;
  logic              is_prog;
  logic              cmd_err_nxt;
  logic              wel;
  logic [7:0]        jedec_byte;

  // ---------------------------------------------------------------
  // Input synchronizers; SS_N flops reset high so no false select.
  // ---------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sck_sync  <= 2'b00;
      ss_sync   <= 2'b11;
      mosi_sync <= 2'b00;
      sck_prev  <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[0], SCK};
      ss_sync   <= {ss_sync[0], SS_N};
      mosi_sync <= {mosi_sync[0], MOSI};
      sck_prev  <= sck_sync[1];
    end
  end

  assign sck_s    = sck_sync[1];
  assign ss_n_s   = ss_sync[1];
  assign mosi_s   = mosi_sync[1];
  assign sck_rise = sck_s & ~sck_prev;
  assign sck_fall = ~sck_s & sck_prev;

  assign rx_next   = {rx, mosi_s};
  assign byte_done = sck_rise && (bit_cnt == 3'd7);
  assign addr_full = {addr_sr, mosi_s};

  assign MISO    = tx[7];
  assign MISO_OE = ~ss_n_s;
  assign BUSY    = ~ss_n_s;

  always_comb begin
    case (byte_cnt)
      2'd0:    jedec_byte = JEDEC_ID[23:16];
      2'd1:    jedec_byte = JEDEC_ID[15:8];
      2'd2:    jedec_byte = JEDEC_ID[7:0];
      default: jedec_byte = 8'h00;
    endcase
  end

  // ---------------------------------------------------------------
  // State register and next-state decode
  // ---------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    cmd_err_nxt = 1'b0;
    if (ss_n_s) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: state_nxt = S_CMD;
        S_CMD: begin
          if (byte_done) begin
            case (rx_next)
              8'h03: state_nxt = S_ADDR;
              8'h05: state_nxt = S_STAT;
              8'h9F: state_nxt = S_JEDEC;
`ifdef SPI_FLASH_RESP_PROGRAM_EN
              8'h02: state_nxt = wel ? S_ADDR : S_IGNORE;
              8'h06: state_nxt = S_DONE;
              8'h04: state_nxt = S_DONE;
`endif
              default: begin
                cmd_err_nxt = 1'b1;
                state_nxt   = S_IGNORE;
              end
            endcase
          end
        end
        S_ADDR: begin
          if (byte_done && (byte_cnt == 2'd2))
            state_nxt = is_prog ? S_PROG : S_READ;
        end
        default: state_nxt = state;
      endcase
    end
  end

  // ---------------------------------------------------------------
  // Shifters, counters and RAM read side
  // ---------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      bit_cnt  <= 3'd0;
      byte_cnt <= 2'd0;
      rx       <= 7'd0;
      addr_sr  <= '0;
      tx       <= 8'h00;
      pf       <= 8'h00;
      rd_q     <= 1'b0;
      is_prog  <= 1'b0;
      MEM_RD   <= 1'b0;
      MEM_ADDR <= '0;
      CMD_ERR  <= 1'b0;
    end else begin
      MEM_RD  <= 1'b0;
      CMD_ERR <= cmd_err_nxt;
      rd_q    <= MEM_RD;
      if (rd_q) pf <= MEM_RDATA;

      if (ss_n_s) begin
        // deselect discards any partial byte
        bit_cnt  <= 3'd0;
        byte_cnt <= 2'd0;
        tx       <= 8'h00;
        is_prog  <= 1'b0;
      end else begin
        if (sck_rise) begin
          bit_cnt <= bit_cnt + 3'd1;
          rx      <= rx_next[6:0];
          if (state == S_CMD && byte_done)
            is_prog <= (rx_next == 8'h02);
          if (state == S_ADDR) begin
            addr_sr <= addr_full[MEM_AW-2:0];
            if (byte_done) begin
              byte_cnt <= byte_cnt + 2'd1;
              if (byte_cnt == 2'd2) begin
                MEM_ADDR <= addr_full;
                MEM_RD   <= ~is_prog;
              end
            end
          end
        end

        // bit_cnt==0 on a fall means the next byte starts: load it
        if (sck_fall) begin
          case (state)
            S_READ: begin
              if (bit_cnt == 3'd0) begin
                tx       <= pf;
                MEM_ADDR <= MEM_ADDR + MEM_AW'(1);
                MEM_RD   <= 1'b1;
              end else begin
                tx <= {tx[6:0], 1'b0};
              end
            end
            S_STAT: begin
              if (bit_cnt == 3'd0) tx <= {6'b0, wel, 1'b0};
              else                 tx <= {tx[6:0], 1'b0};
            end
            S_JEDEC: begin
              if (bit_cnt == 3'd0) begin
                tx <= jedec_byte;
                if (byte_cnt != 2'd3) byte_cnt <= byte_cnt + 2'd1;
              end else begin
                tx <= {tx[6:0], 1'b0};
              end
            end
            default: tx <= 8'h00;
          endcase
        end
      end

`ifdef SPI_FLASH_RESP_PROGRAM_EN
      // page wrap: only the low byte advances after each write
      if (MEM_WE) MEM_ADDR[7:0] <= MEM_ADDR[7:0] + 8'd1;
`endif
    end
  end

`ifdef SPI_FLASH_RESP_PROGRAM_EN
  logic ss_prev;
  logic ss_rise;

  assign ss_rise = ss_n_s & ~ss_prev;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ss_prev   <= 1'b1;
      wel       <= 1'b0;
      MEM_WE    <= 1'b0;
      MEM_WDATA <= 8'h00;
    end else begin
      ss_prev <= ss_n_s;
      MEM_WE  <= 1'b0;
      if (ss_rise && is_prog) wel <= 1'b0;
      if (!ss_n_s && state == S_CMD && byte_done) begin
        if (rx_next == 8'h06)      wel <= 1'b1;
        else if (rx_next == 8'h04) wel <= 1'b0;
      end
      if (!ss_n_s && state == S_PROG && byte_done) begin
        MEM_WE    <= 1'b1;
        MEM_WDATA <= rx_next;
      end
    end
  end
`else
  assign wel       = 1'b0;
  assign MEM_WE    = 1'b0;
  assign MEM_WDATA = 8'h00;
`endif

endmodule

// File: tb/tb_spi_flash_responder.sv
// tb_spi_flash_responder
//   Drives spi_flash_responder as an SPI mode-0 master and compares MISO
//   bytes, RAM strobes and CMD_ERR against a flash model held in this file.
module tb_spi_flash_responder;
  localparam int AW    = 13;
  localparam int DEPTH = 1 << AW;
  localparam int HALF  = 50;   // SCK half period = 5 CLK

  logic          CLK = 1'b0;
  logic          RESET, SCK, SS_N, MOSI;
  logic          MISO, MISO_OE, MEM_RD, MEM_WE, BUSY, CMD_ERR;
  logic [AW-1:0] MEM_ADDR;
  logic [7:0]    MEM_RDATA = 8'h00;
  logic [7:0]    MEM_WDATA;

  logic [7:0]    ram [DEPTH];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  spi_flash_responder #(.MEM_AW(AW), .JEDEC_ID(24'h20BA18)) dut (
    .CLK(CLK), .RESET(RESET), .SCK(SCK), .SS_N(SS_N), .MOSI(MOSI),
    .MISO(MISO), .MISO_OE(MISO_OE), .MEM_ADDR(MEM_ADDR), .MEM_RD(MEM_RD),
    .MEM_RDATA(MEM_RDATA), .MEM_WE(MEM_WE), .MEM_WDATA(MEM_WDATA),
    .BUSY(BUSY), .CMD_ERR(CMD_ERR)
  );

  // 1-cycle-latency RAM read port
  always @(posedge CLK) if (MEM_RD) MEM_RDATA <= ram[MEM_ADDR];

  // strobe logs, sampled away from the active edge
  logic [AW-1:0]   rd_log[$];
  logic [AW+7:0]   wr_log[$];
  int              err_cycles = 0;
  always @(negedge CLK) begin
    if (MEM_RD)  rd_log.push_back(MEM_ADDR);
    if (MEM_WE)  wr_log.push_back({MEM_ADDR, MEM_WDATA});
    if (CMD_ERR) err_cycles++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  int rd_mark, wr_mark, err_mark;
  logic wel_m = 1'b0;

  task automatic spi_bits(input logic [7:0] mo, input int nb, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 7; i > 7 - nb; i--) begin
      MOSI = mo[i];
      #HALF;
      mi[i] = MISO;
      SCK = 1'b1;
      #HALF;
      SCK = 1'b0;
    end
  endtask

  task automatic mark();
    rd_mark  = rd_log.size();
    wr_mark  = wr_log.size();
    err_mark = err_cycles;
  endtask

  task automatic xact();
    logic [7:0] b;
    rxq.delete();
    mark();
    SS_N = 1'b0;
    #HALF;
    chk("busy_selected", BUSY, 1);
    chk("oe_selected", MISO_OE, 1);
    foreach (txq[i]) begin
      spi_bits(txq[i], 8, b);
      rxq.push_back(b);
    end
    #HALF;
    SS_N = 1'b1;
    #(HALF * 2);
    chk("busy_deselected", BUSY, 0);
    chk("oe_deselected", MISO_OE, 0);
  endtask

  task automatic do_read(input logic [23:0] a, input int n);
    int cnt, idx;
    txq.delete();
    txq.push_back(8'h03);
    txq.push_back(a[23:16]);
    txq.push_back(a[15:8]);
    txq.push_back(a[7:0]);
    for (int i = 0; i < n; i++) txq.push_back(8'($urandom));
    xact();
    for (int i = 0; i < 4; i++) chk("read_hdr_miso", rxq[i], 0);
    for (int i = 0; i < n; i++) begin
      idx = (int'(a) + i) % DEPTH;
      chk("read_data", rxq[4 + i], ram[idx]);
    end
    // the idle-return SCK fall after the last byte may add one more prefetch
    cnt = rd_log.size() - rd_mark;
    chk("read_strobe_count", (cnt == n + 1) || (cnt == n + 2), 1);
    for (int j = 0; j <= n; j++) begin
      idx = (int'(a) + j) % DEPTH;
      if (rd_mark + j < rd_log.size()) chk("read_strobe_addr", rd_log[rd_mark + j], idx);
      else                             chk("read_strobe_missing", 32'hDEAD_BEEF, idx);
    end
    chk("read_no_err", err_cycles - err_mark, 0);
  endtask

  task automatic do_simple(input logic [7:0] op, input int n);
    txq.delete();
    txq.push_back(op);
    for (int i = 0; i < n; i++) txq.push_back(8'($urandom));
    xact();
  endtask

  task automatic do_stat(input int n);
    do_simple(8'h05, n);
    chk("stat_cmd_miso", rxq[0], 0);
    for (int i = 1; i <= n; i++) chk("stat_byte", rxq[i], {6'b0, wel_m, 1'b0});
    chk("stat_no_err", err_cycles - err_mark, 0);
  endtask

  task automatic do_bad(input logic [7:0] op);
    do_simple(op, 2);
    chk("bad_err_pulse", err_cycles - err_mark, 1);
    for (int i = 0; i < 3; i++) chk("bad_miso", rxq[i], 0);
    chk("bad_no_rd", rd_log.size() - rd_mark, 0);
    chk("bad_no_we", wr_log.size() - wr_mark, 0);
  endtask

  function automatic bit supported(input logic [7:0] op);
`ifdef SPI_FLASH_RESP_PROGRAM_EN
    return op == 8'h03 || op == 8'h05 || op == 8'h9F ||
           op == 8'h02 || op == 8'h04 || op == 8'h06;
`else
    return op == 8'h03 || op == 8'h05 || op == 8'h9F;
`endif
  endfunction

`ifdef SPI_FLASH_RESP_PROGRAM_EN
  task automatic do_prog(input logic [23:0] a, input int n, input bit expect_write);
    logic [7:0]    d[$];
    logic [AW-1:0] base, wa;
    txq.delete();
    txq.push_back(8'h02);
    txq.push_back(a[23:16]);
    txq.push_back(a[15:8]);
    txq.push_back(a[7:0]);
    for (int i = 0; i < n; i++) d.push_back(8'($urandom));
    if (a == 24'h0000FE && n == 3) begin
      d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33;
    end
    foreach (d[i]) txq.push_back(d[i]);
    xact();
    chk("prog_no_err", err_cycles - err_mark, 0);
    chk("prog_we_count", wr_log.size() - wr_mark, expect_write ? n : 0);
    base = a[AW-1:0];
    if (expect_write) begin
      for (int i = 0; i < n && wr_mark + i < wr_log.size(); i++) begin
        wa = {base[AW-1:8], 8'(base[7:0] + 8'(i))};
        chk("prog_we", wr_log[wr_mark + i], {wa, d[i]});
        ram[wa] = d[i];
      end
    end
    wel_m = 1'b0;
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  b;
    logic [7:0]  op;
    logic [23:0] ra;

    RESET = 1'b1; SS_N = 1'b1; SCK = 1'b0; MOSI = 1'b0;
    for (int i = 0; i < DEPTH; i++) ram[i] = 8'($urandom);
    ram[13'h0010] = 8'hA5; ram[13'h0011] = 8'h3C; ram[13'h0012] = 8'hF0;
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    chk("rst_miso", MISO, 0);
    chk("rst_oe", MISO_OE, 0);
    chk("rst_rd", MEM_RD, 0);
    chk("rst_we", MEM_WE, 0);
    chk("rst_addr", MEM_ADDR, 0);
    chk("rst_wdata", MEM_WDATA, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_err", CMD_ERR, 0);
    RESET = 1'b0;
    repeat (4) @(negedge CLK);

    do_read(24'h000010, 3);
    do_read(24'h001FFF, 2);
    for (int k = 0; k < 6; k++) begin
      ra = 24'($urandom);
      do_read(ra, int'($urandom_range(1, 5)));
    end

    do_simple(8'h9F, 5);
    chk("jedec_cmd_miso", rxq[0], 0);
    chk("jedec_b0", rxq[1], 8'h20);
    chk("jedec_b1", rxq[2], 8'hBA);
    chk("jedec_b2", rxq[3], 8'h18);
    chk("jedec_b3", rxq[4], 8'h00);
    chk("jedec_b4", rxq[5], 8'h00);
    chk("jedec_no_err", err_cycles - err_mark, 0);

    do_stat(2);
    do_bad(8'hAB);
    for (int k = 0; k < 4; k++) begin
      op = 8'($urandom);
      while (supported(op)) op = 8'($urandom);
      do_bad(op);
    end

    // deselect in the middle of the first address byte
    mark();
    SS_N = 1'b0;
    #HALF;
    spi_bits(8'h03, 8, b);
    spi_bits(8'h12, 5, b);
    #HALF;
    SS_N = 1'b1;
    #(HALF * 2);
    chk("abort_oe", MISO_OE, 0);
    chk("abort_busy", BUSY, 0);
    chk("abort_miso", MISO, 0);
    chk("abort_no_rd", rd_log.size() - rd_mark, 0);
    chk("abort_no_we", wr_log.size() - wr_mark, 0);
    do_read(24'h000000, 2);

`ifdef SPI_FLASH_RESP_PROGRAM_EN
    do_simple(8'h06, 0);
    chk("wren_no_err", err_cycles - err_mark, 0);
    wel_m = 1'b1;
    do_stat(2);
    do_prog(24'h0000FE, 3, 1'b1);
    do_stat(1);
    do_read(24'h0000FE, 3);
    // program refused without WEL
    do_prog(24'h000100, 2, 1'b0);
    do_simple(8'h06, 0);
    wel_m = 1'b1;
    do_simple(8'h04, 0);
    chk("wrdi_no_err", err_cycles - err_mark, 0);
    wel_m = 1'b0;
    do_stat(1);
    for (int k = 0; k < 3; k++) begin
      do_simple(8'h06, 0);
      wel_m = 1'b1;
      ra = 24'($urandom);
      do_prog(ra, int'($urandom_range(1, 4)), 1'b1);
      do_read(ra, 1);
    end
`else
    do_bad(8'h06);
    do_stat(1);
    do_bad(8'h04);
    do_bad(8'h02);
    chk("we_never", wr_log.size(), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
